// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types and constants for the WS2812 receiver
package ws2812_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_e;

   localparam logic [1:0] ERR_GLITCH  = 2'b01;
   localparam logic [1:0] ERR_PARTIAL = 2'b10;
   localparam logic [1:0] ERR_STUCK   = 2'b11;

   localparam int BITS_PER_LED = 24;

endpackage

// File: rtl/ws2812_din_sync.sv
// rtl/ws2812_din_sync.sv - two-flop synchroniser and edge detect for the data line
module ws2812_din_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Bring din into the clock domain and keep one extra sample for edges
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= din_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire stream decoder with frame and error reporting
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int BIT_THRESH   = 30,
   parameter int MIN_HIGH     = 5,
   parameter int MAX_HIGH     = 100,
   parameter int RESET_CYCLES = 2500
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        din_i,
   output logic [23:0] colour_o,
   output logic [7:0]  led_index_o,
   output logic        colour_valid_o,
   output logic        frame_done_o,
   output logic [7:0]  pixel_count_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic        ready_o
);

   localparam int            CW       = $clog2(RESET_CYCLES + 1);
   localparam logic [CW-1:0] GAP_C    = CW'(RESET_CYCLES);
   localparam logic [CW-1:0] THRESH_C = CW'(BIT_THRESH);
   localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH);
   localparam logic [CW-1:0] MAX_C    = CW'(MAX_HIGH);
   localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_LED - 1);

   logic s;
   logic rise;
   logic fall;

   ws2812_din_sync u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .din_i   (din_i),
      .level_o (s),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   state_e        state_q;
   logic [CW-1:0] lo_cnt_q;
   logic [CW-1:0] hi_cnt_q;
   logic [4:0]    bit_cnt_q;
   logic [7:0]    idx_q;
   logic [23:0]   shift_q;
   logic [23:0]   colour_q;
   logic [7:0]    led_index_q;
   logic          colour_valid_q;
   logic          frame_done_q;
   logic [7:0]    pixel_count_q;
   logic          err_q;
   logic [1:0]    err_code_q;
   logic          ready_q;

   logic [CW-1:0] hi_width_d;
   logic          bit_d;
   logic [23:0]   word_d;

   // Width of the pulse ending now counts its first high cycle as well
   always_comb begin
      hi_width_d = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + CW'(1);
      bit_d      = (hi_width_d >= THRESH_C);
      word_d     = {shift_q[22:0], bit_d};
   end

   // Decoder FSM: counters, shift register and all registered outputs
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= SYNC;
         lo_cnt_q       <= '0;
         hi_cnt_q       <= '0;
         bit_cnt_q      <= '0;
         idx_q          <= '0;
         shift_q        <= '0;
         colour_q       <= '0;
         led_index_q    <= '0;
         colour_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         pixel_count_q  <= '0;
         err_q          <= 1'b0;
         err_code_q     <= 2'b00;
         ready_q        <= 1'b0;
      end else begin
         colour_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         err_q          <= 1'b0;
         case (state_q)
            SYNC: begin
               if (s) begin
                  lo_cnt_q <= '0;
               end else if (lo_cnt_q >= GAP_C - CW'(1)) begin
                  // A full gap seen: the gap that got us here must not fire again
                  state_q   <= LOW;
                  ready_q   <= 1'b1;
                  lo_cnt_q  <= GAP_C;
                  bit_cnt_q <= '0;
                  idx_q     <= '0;
               end else begin
                  lo_cnt_q <= lo_cnt_q + CW'(1);
               end
            end
            LOW: begin
               if (rise) begin
                  hi_cnt_q <= '0;
                  state_q  <= HIGH;
               end else if (lo_cnt_q != GAP_C) begin
                  lo_cnt_q <= lo_cnt_q + CW'(1);
                  // Saturation makes this fire once per low period
                  if (lo_cnt_q == GAP_C - CW'(1)) begin
                     if (bit_cnt_q != '0) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_PARTIAL;
                     end
                     if (idx_q != '0) begin
                        frame_done_q  <= 1'b1;
                        pixel_count_q <= idx_q;
                     end
                     idx_q     <= '0;
                     bit_cnt_q <= '0;
                  end
               end
            end
            HIGH: begin
               if (fall) begin
                  state_q  <= LOW;
                  lo_cnt_q <= CW'(1);
                  if (hi_width_d < MIN_C) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_GLITCH;
                  end else if (bit_cnt_q == LAST_BIT) begin
                     shift_q        <= word_d;
                     colour_q       <= word_d;
                     led_index_q    <= idx_q;
                     colour_valid_q <= 1'b1;
                     bit_cnt_q      <= '0;
                     if (idx_q != 8'hFF) begin
                        idx_q <= idx_q + 8'd1;
                     end
                  end else begin
                     shift_q   <= word_d;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end else if (hi_cnt_q >= MAX_C) begin
                  // Line held high too long: drop everything and re-sync
                  err_q      <= 1'b1;
                  err_code_q <= ERR_STUCK;
                  state_q    <= SYNC;
                  ready_q    <= 1'b0;
                  lo_cnt_q   <= '0;
                  bit_cnt_q  <= '0;
                  idx_q      <= '0;
               end else if (hi_cnt_q != '1) begin
                  hi_cnt_q <= hi_cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= SYNC;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign colour_o       = colour_q;
   assign led_index_o    = led_index_q;
   assign colour_valid_o = colour_valid_q;
   assign frame_done_o   = frame_done_q;
   assign pixel_count_o  = pixel_count_q;
   assign err_o          = err_q;
   assign err_code_o     = err_code_q;
   assign ready_o        = ready_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for the WS2812 receiver
module tb_ws2812_rx;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        din_i;
   logic [23:0] colour_o;
   logic [7:0]  led_index_o;
   logic        colour_valid_o;
   logic        frame_done_o;
   logic [7:0]  pixel_count_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic        ready_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] cv_q[$];
   logic [7:0]  fd_q[$];
   logic [1:0]  er_q[$];
   logic [31:0] exp_cv[$];
   int          dbl = 0;
   logic        pv_cv = 1'b0;
   logic        pv_fd = 1'b0;
   logic        pv_er = 1'b0;

   ws2812_rx dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .din_i          (din_i),
      .colour_o       (colour_o),
      .led_index_o    (led_index_o),
      .colour_valid_o (colour_valid_o),
      .frame_done_o   (frame_done_o),
      .pixel_count_o  (pixel_count_o),
      .err_o          (err_o),
      .err_code_o     (err_code_o),
      .ready_o        (ready_o)
   );

   always #5 clk_i = ~clk_i;

   // Record every strobe and note any strobe lasting more than one cycle
   always @(negedge clk_i) begin
      if (reset_i) begin
         pv_cv = 1'b0;
         pv_fd = 1'b0;
         pv_er = 1'b0;
      end else begin
         if (colour_valid_o) cv_q.push_back({led_index_o, colour_o});
         if (frame_done_o)   fd_q.push_back(pixel_count_o);
         if (err_o)          er_q.push_back(err_code_o);
         if ((colour_valid_o && pv_cv) || (frame_done_o && pv_fd) || (err_o && pv_er)) dbl++;
         pv_cv = colour_valid_o;
         pv_fd = frame_done_o;
         pv_er = err_o;
      end
   end

   function automatic logic [31:0] px(input int i, input logic [23:0] w);
      return {(i > 255) ? 8'd255 : 8'(i), w};
   endfunction

   task automatic clear_q();
      cv_q.delete();
      fd_q.delete();
      er_q.delete();
      exp_cv.delete();
   endtask

   task automatic drive_pulse(input int hi, input int lo);
      din_i = 1'b1;
      repeat (hi) @(negedge clk_i);
      din_i = 1'b0;
      repeat (lo) @(negedge clk_i);
   endtask

   task automatic send_bit(input logic b);
      int hi;
      hi = b ? 40 : 20;
      drive_pulse(hi, 62 - hi);
   endtask

   task automatic send_word(input logic [23:0] w, input bit rnd);
      for (int b = 23; b >= 0; b--) begin
         int hi;
         int lo;
         if (rnd) begin
            hi = w[b] ? int'($urandom_range(90, 32)) : int'($urandom_range(28, 6));
            lo = int'($urandom_range(50, 6));
         end else begin
            hi = w[b] ? 40 : 20;
            lo = 62 - hi;
         end
         drive_pulse(hi, lo);
      end
   endtask

   task automatic gap(input int n);
      din_i = 1'b0;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      din_i   = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++; if (colour_o !== 24'h0)      begin errors++; $display("FAIL rst_colour got %h required 000000", colour_o); end
      checks++; if (led_index_o !== 8'h0)    begin errors++; $display("FAIL rst_index got %h required 00", led_index_o); end
      checks++; if (colour_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", colour_valid_o); end
      checks++; if (frame_done_o !== 1'b0)   begin errors++; $display("FAIL rst_frame got %b required 0", frame_done_o); end
      checks++; if (pixel_count_o !== 8'h0)  begin errors++; $display("FAIL rst_count got %h required 00", pixel_count_o); end
      checks++; if (err_o !== 1'b0)          begin errors++; $display("FAIL rst_err got %b required 0", err_o); end
      checks++; if (err_code_o !== 2'b00)    begin errors++; $display("FAIL rst_code got %b required 00", err_code_o); end
      checks++; if (ready_o !== 1'b0)        begin errors++; $display("FAIL rst_ready got %b required 0", ready_o); end
      reset_i = 1'b0;
      repeat (2499) @(negedge clk_i);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_early got %b required 0", ready_o); end
      @(negedge clk_i);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_up got %b required 1", ready_o); end
      checks++;
      if (cv_q.size() + fd_q.size() + er_q.size() != 0) begin
         errors++; $display("FAIL rst_strobes got %0d required 0", cv_q.size() + fd_q.size() + er_q.size());
      end
   endtask

   task automatic test_three_pixel();
      logic [23:0] words [3];
      int hi;
      words[0] = 24'hAABBCD;
      words[1] = 24'hDDEEFE;
      words[2] = 24'h112244;
      clear_q();
      for (int i = 0; i < 3; i++) exp_cv.push_back(px(i, words[i]));
      for (int b = 23; b >= 1; b--) send_bit(words[0][b]);
      hi = words[0][0] ? 40 : 20;
      din_i = 1'b1;
      repeat (hi) @(negedge clk_i);
      din_i = 1'b0;
      @(negedge clk_i);
      checks++; if (colour_valid_o !== 1'b0) begin errors++; $display("FAIL lat_c1 got %b required 0", colour_valid_o); end
      @(negedge clk_i);
      checks++; if (colour_valid_o !== 1'b0) begin errors++; $display("FAIL lat_c2 got %b required 0", colour_valid_o); end
      @(negedge clk_i);
      checks++; if (colour_valid_o !== 1'b1) begin errors++; $display("FAIL lat_c3 got %b required 1", colour_valid_o); end
      checks++; if (colour_o !== words[0]) begin errors++; $display("FAIL lat_colour got %h required %h", colour_o, words[0]); end
      repeat (62 - hi - 3) @(negedge clk_i);
      send_word(words[1], 1'b0);
      send_word(words[2], 1'b0);
      gap(2600);
      checks++;
      if (cv_q.size() != 3) begin errors++; $display("FAIL tp_cv_count got %0d required 3", cv_q.size()); end
      for (int i = 0; i < cv_q.size() && i < 3; i++) begin
         checks++;
         if (cv_q[i] !== exp_cv[i]) begin errors++; $display("FAIL tp_pixel%0d got %h required %h", i, cv_q[i], exp_cv[i]); end
      end
      checks++;
      if (fd_q.size() != 1) begin errors++; $display("FAIL tp_fd_count got %0d required 1", fd_q.size()); end
      else if (fd_q[0] !== 8'd3) begin errors++; $display("FAIL tp_pixcount got %0d required 3", fd_q[0]); end
      checks++;
      if (er_q.size() != 0) begin errors++; $display("FAIL tp_err got %0d required 0", er_q.size()); end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 2; f++) begin
         int n;
         n = int'($urandom_range(4, 1));
         clear_q();
         for (int i = 0; i < n; i++) begin
            logic [23:0] w;
            w = 24'($urandom);
            exp_cv.push_back(px(i, w));
            send_word(w, 1'b1);
         end
         gap(2600);
         checks++;
         if (cv_q.size() != exp_cv.size()) begin errors++; $display("FAIL rnd%0d_cv_count got %0d required %0d", f, cv_q.size(), exp_cv.size()); end
         for (int i = 0; i < cv_q.size() && i < exp_cv.size(); i++) begin
            checks++;
            if (cv_q[i] !== exp_cv[i]) begin errors++; $display("FAIL rnd%0d_pixel%0d got %h required %h", f, i, cv_q[i], exp_cv[i]); end
         end
         checks++;
         if (fd_q.size() != 1) begin errors++; $display("FAIL rnd%0d_fd_count got %0d required 1", f, fd_q.size()); end
         else if (fd_q[0] !== 8'(n)) begin errors++; $display("FAIL rnd%0d_pixcount got %0d required %0d", f, fd_q[0], n); end
         checks++;
         if (er_q.size() != 0) begin errors++; $display("FAIL rnd%0d_err got %0d required 0", f, er_q.size()); end
      end
   endtask

   task automatic test_partial();
      logic [23:0] w;
      logic [23:0] w2;
      w  = 24'($urandom);
      w2 = 24'($urandom);
      clear_q();
      for (int b = 23; b >= 12; b--) send_bit(w[b]);
      gap(2600);
      checks++;
      if (er_q.size() != 1) begin errors++; $display("FAIL part_err_count got %0d required 1", er_q.size()); end
      else if (er_q[0] !== 2'b10) begin errors++; $display("FAIL part_err_code got %b required 10", er_q[0]); end
      checks++; if (err_code_o !== 2'b10) begin errors++; $display("FAIL part_code_hold got %b required 10", err_code_o); end
      checks++; if (cv_q.size() != 0) begin errors++; $display("FAIL part_cv got %0d required 0", cv_q.size()); end
      checks++; if (fd_q.size() != 0) begin errors++; $display("FAIL part_fd got %0d required 0", fd_q.size()); end
      send_word(w2, 1'b0);
      gap(2600);
      checks++;
      if (cv_q.size() != 1) begin errors++; $display("FAIL part_next_count got %0d required 1", cv_q.size()); end
      else if (cv_q[0] !== px(0, w2)) begin errors++; $display("FAIL part_next_pixel got %h required %h", cv_q[0], px(0, w2)); end
      checks++;
      if (fd_q.size() != 1) begin errors++; $display("FAIL part_next_fd got %0d required 1", fd_q.size()); end
      else if (fd_q[0] !== 8'd1) begin errors++; $display("FAIL part_next_pixcount got %0d required 1", fd_q[0]); end
   endtask

   task automatic test_glitch();
      logic [23:0] w;
      w = 24'($urandom);
      clear_q();
      for (int b = 23; b >= 0; b--) begin
         if (b == 11) begin
            drive_pulse(w[b] ? 40 : 20, 20);
            drive_pulse(2, 20);
         end else begin
            send_bit(w[b]);
         end
      end
      gap(2600);
      checks++;
      if (er_q.size() != 1) begin errors++; $display("FAIL gl_err_count got %0d required 1", er_q.size()); end
      else if (er_q[0] !== 2'b01) begin errors++; $display("FAIL gl_err_code got %b required 01", er_q[0]); end
      checks++;
      if (cv_q.size() != 1) begin errors++; $display("FAIL gl_cv_count got %0d required 1", cv_q.size()); end
      else if (cv_q[0] !== px(0, w)) begin errors++; $display("FAIL gl_pixel got %h required %h", cv_q[0], px(0, w)); end
      checks++;
      if (fd_q.size() != 1) begin errors++; $display("FAIL gl_fd got %0d required 1", fd_q.size()); end
   endtask

   task automatic test_stuck();
      logic [23:0] w;
      logic [23:0] w2;
      w  = 24'($urandom);
      w2 = 24'($urandom) | 24'h1;
      clear_q();
      for (int b = 23; b >= 14; b--) send_bit(w[b]);
      din_i = 1'b1;
      repeat (150) @(negedge clk_i);
      din_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if (er_q.size() != 1) begin errors++; $display("FAIL st_err_count got %0d required 1", er_q.size()); end
      else if (er_q[0] !== 2'b11) begin errors++; $display("FAIL st_err_code got %b required 11", er_q[0]); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL st_ready got %b required 0", ready_o); end
      gap(1000);
      send_word(w, 1'b0);
      gap(100);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL st_ready_hold got %b required 0", ready_o); end
      gap(2500);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL st_ready_back got %b required 1", ready_o); end
      checks++; if (cv_q.size() != 0) begin errors++; $display("FAIL st_ignored got %0d required 0", cv_q.size()); end
      checks++; if (fd_q.size() != 0) begin errors++; $display("FAIL st_fd got %0d required 0", fd_q.size()); end
      send_word(w2, 1'b0);
      gap(2600);
      checks++;
      if (cv_q.size() != 1) begin errors++; $display("FAIL st_next_count got %0d required 1", cv_q.size()); end
      else if (cv_q[0] !== px(0, w2)) begin errors++; $display("FAIL st_next_pixel got %h required %h", cv_q[0], px(0, w2)); end
      checks++;
      if (fd_q.size() != 1) begin errors++; $display("FAIL st_next_fd got %0d required 1", fd_q.size()); end
   endtask

   task automatic test_async_reset();
      logic [23:0] w;
      logic [23:0] w2;
      w  = 24'($urandom);
      w2 = 24'($urandom);
      clear_q();
      for (int b = 23; b >= 15; b--) send_bit(w[b]);
      din_i = 1'b1;
      repeat (10) @(negedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      checks++; if (colour_o !== 24'h0)     begin errors++; $display("FAIL ar_colour got %h required 000000", colour_o); end
      checks++; if (led_index_o !== 8'h0)   begin errors++; $display("FAIL ar_index got %h required 00", led_index_o); end
      checks++; if (pixel_count_o !== 8'h0) begin errors++; $display("FAIL ar_count got %h required 00", pixel_count_o); end
      checks++; if (err_code_o !== 2'b00)   begin errors++; $display("FAIL ar_code got %b required 00", err_code_o); end
      checks++; if (ready_o !== 1'b0)       begin errors++; $display("FAIL ar_ready got %b required 0", ready_o); end
      @(negedge clk_i);
      din_i   = 1'b0;
      reset_i = 1'b0;
      gap(2600);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ar_resync got %b required 1", ready_o); end
      checks++; if (cv_q.size() != 0) begin errors++; $display("FAIL ar_cv got %0d required 0", cv_q.size()); end
      send_word(w2, 1'b0);
      gap(2600);
      checks++;
      if (cv_q.size() != 1) begin errors++; $display("FAIL ar_next_count got %0d required 1", cv_q.size()); end
      else if (cv_q[0] !== px(0, w2)) begin errors++; $display("FAIL ar_next_pixel got %h required %h", cv_q[0], px(0, w2)); end
      checks++;
      if (fd_q.size() != 1) begin errors++; $display("FAIL ar_next_fd got %0d required 1", fd_q.size()); end
      checks++; if (er_q.size() != 0) begin errors++; $display("FAIL ar_err got %0d required 0", er_q.size()); end
   endtask

   task automatic test_strobe_width();
      checks++;
      if (dbl != 0) begin errors++; $display("FAIL strobe_width got %0d long strobes required 0", dbl); end
   endtask

   initial begin
      reset_i = 1'b1;
      din_i   = 1'b0;
      test_reset();
      test_three_pixel();
      test_random_frames();
      test_partial();
      test_glitch();
      test_stuck();
      test_async_reset();
      test_strobe_width();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
